ttl_updown_counter_n: RTL and testbench

Parametrised synchronous up/down counter modelling the 74x169/74x191 family. Generalises the fixed 8-bit counter with configurable width, programmable modulus, selectable clock-enable qualification, and cascade outputs (terminal count, ripple-carry, wrap pulse, compare match). It sits in `rtl/ttl_sync` and replaces chains of discrete TTL counters in the video timing and scroll address paths; several instances cascade through `rco_n` → `ent_n`.

---
 rtl/ttl_updown_counter_n.sv | 128 ++++++++++++
 tb/tb_ttl_updown_counter_n.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/ttl_updown_counter_n.sv
// rtl/ttl_updown_counter_n.sv - parametrised synchronous up/down counter (74x169/74x191 family)
//
// Purpose: modulo-MODULUS up/down counter with clear, parallel load (clamped to
// the count range), dual count enables and cascade outputs. Instances chain
// rco_n -> ent_n with a shared cen to form wider synchronous counters.
//
// Parameters:
//   WIDTH    counter width, 2..32
//   MODULUS  count range 0..MODULUS-1, 2..2**WIDTH
//   EDGE_CEN 1: tick on rising edge of cen, 0: cen is a level enable
//   INIT     value of Q after reset, < MODULUS
//
// Ports:
//   clk        system clock, rising edge
//   Reset      asynchronous active-high reset
//   cen        clock enable (qualified by EDGE_CEN)
//   clr_n      synchronous clear, active low (highest priority)
//   load_n     synchronous parallel load, active low
//   ent_n      count enable T, active low; also gates rco_n
//   enp_n      count enable P, active low
//   direction  1 = up, 0 = down
//   P          parallel load data
//   CMP        compare value
//   Q          registered count value
//   tc         terminal count (combinational)
//   rco_n      ripple carry out, active low (combinational)
//   wrap       one-clk pulse after a counting tick that crossed the terminal value
//   match      registered (Q == CMP), lags Q by one clk

module ttl_updown_counter_n #(
  parameter int              WIDTH    = 8,
  parameter longint unsigned MODULUS  = 64'd1 << WIDTH,
  parameter int              EDGE_CEN = 1,
  parameter longint unsigned INIT     = 64'd0
) (
  input  logic             clk,
  input  logic             Reset,
  input  logic             cen,
  input  logic             clr_n,
  input  logic             load_n,
  input  logic             ent_n,
  input  logic             enp_n,
  input  logic             direction,
  input  logic [WIDTH-1:0] P,
  input  logic [WIDTH-1:0] CMP,
  output logic [WIDTH-1:0] Q,
  output logic             tc,
  output logic             rco_n,
  output logic             wrap,
  output logic             match
);

  // Parameter legality is checked at elaboration so a bad instance never builds.
  if (WIDTH < 2 || WIDTH > 32) begin : g_bad_width
    $error("ttl_updown_counter_n: WIDTH must be 2..32");
  end
  if (MODULUS < 64'd2 || MODULUS > (64'd1 << WIDTH)) begin : g_bad_modulus
    $error("ttl_updown_counter_n: MODULUS must be 2..2**WIDTH");
  end
  if (INIT >= MODULUS) begin : g_bad_init
    $error("ttl_updown_counter_n: INIT must be below MODULUS");
  end

  localparam logic [WIDTH-1:0] MAX_Q  = WIDTH'(MODULUS - 64'd1);
  localparam logic [WIDTH-1:0] INIT_Q = WIDTH'(INIT);

  logic             last_cen;
  logic             tick;
  logic             count_en;
  logic             p_in_range;
  logic [WIDTH-1:0] q_next;
  logic             wrap_next;

  // Edge mode: last_cen resets to 0, so a cen already high at reset release
  // produces a tick on the first edge.
  assign tick       = (EDGE_CEN != 0) ? (cen & ~last_cen) : cen;
  assign count_en   = ~ent_n & ~enp_n;
  // Compare in 64 bits so MODULUS = 2**WIDTH is representable.
  assign p_in_range = (64'(P) < MODULUS);

  always_comb begin
    q_next    = Q;
    wrap_next = 1'b0;
    if (tick) begin
      if (!clr_n) begin
        q_next = '0;
      end else if (!load_n) begin
        q_next = p_in_range ? P : MAX_Q;
      end else if (count_en) begin
        if (direction) begin
          if (Q == MAX_Q) begin
            q_next    = '0;
            wrap_next = 1'b1;
          end else begin
            q_next = Q + WIDTH'(1);
          end
        end else begin
          if (Q == '0) begin
            q_next    = MAX_Q;
            wrap_next = 1'b1;
          end else begin
            q_next = Q - WIDTH'(1);
          end
        end
      end
    end
  end

  always_ff @(posedge clk or posedge Reset) begin
    if (Reset) begin
      Q        <= INIT_Q;
      last_cen <= 1'b0;
      wrap     <= 1'b0;
      match    <= 1'b0;
    end else begin
      Q        <= q_next;
      last_cen <= cen;
      wrap     <= wrap_next;
      // Uses the pre-edge Q, so match trails Q by one clk.
      match    <= (Q == CMP);
    end
  end

  // Terminal count is independent of the enables; rco_n is gated by ent_n only.
  assign tc    = (direction & (Q == MAX_Q)) | (~direction & (Q == '0));
  assign rco_n = ~(tc & ~ent_n);

endmodule

// File: tb/tb_ttl_updown_counter_n.sv
// tb/tb_ttl_updown_counter_n.sv - directed scoreboard bench for ttl_updown_counter_n

module tb_ttl_updown_counter_n;

  logic clk;
  logic rst;

  // Instance A: WIDTH=8, INIT=5A, edge-qualified cen
  logic       cen_a, clr_n_a, load_n_a, ent_n_a, enp_n_a, dir_a;
  logic [7:0] p_a, cmp_a, q_a;
  logic       tc_a, rco_n_a, wrap_a, match_a;

  // Instance B: WIDTH=4, MODULUS=10, level cen
  logic       cen_b, clr_n_b, load_n_b, ent_n_b, enp_n_b, dir_b;
  logic [3:0] p_b, cmp_b, q_b;
  logic       tc_b, rco_n_b, wrap_b, match_b;

  // Cascade: two WIDTH=4 stages, level cen
  logic       c_cen, c_clr_n, c_load_n, c_ent_n0, c_enp_n, c_dir;
  logic [7:0] c_p, c_cmp;
  logic [3:0] q_c0, q_c1;
  logic       tc_c0, tc_c1, rco_n_c0, rco_n_c1, wrap_c0, wrap_c1, match_c0, match_c1;

  ttl_updown_counter_n #(.WIDTH(8), .EDGE_CEN(1), .INIT(64'h5A)) u_a (
    .clk(clk), .Reset(rst), .cen(cen_a), .clr_n(clr_n_a), .load_n(load_n_a),
    .ent_n(ent_n_a), .enp_n(enp_n_a), .direction(dir_a), .P(p_a), .CMP(cmp_a),
    .Q(q_a), .tc(tc_a), .rco_n(rco_n_a), .wrap(wrap_a), .match(match_a)
  );

  ttl_updown_counter_n #(.WIDTH(4), .MODULUS(64'd10), .EDGE_CEN(0), .INIT(64'd0)) u_b (
    .clk(clk), .Reset(rst), .cen(cen_b), .clr_n(clr_n_b), .load_n(load_n_b),
    .ent_n(ent_n_b), .enp_n(enp_n_b), .direction(dir_b), .P(p_b), .CMP(cmp_b),
    .Q(q_b), .tc(tc_b), .rco_n(rco_n_b), .wrap(wrap_b), .match(match_b)
  );

  ttl_updown_counter_n #(.WIDTH(4), .EDGE_CEN(0)) u_c0 (
    .clk(clk), .Reset(rst), .cen(c_cen), .clr_n(c_clr_n), .load_n(c_load_n),
    .ent_n(c_ent_n0), .enp_n(c_enp_n), .direction(c_dir), .P(c_p[3:0]), .CMP(c_cmp[3:0]),
    .Q(q_c0), .tc(tc_c0), .rco_n(rco_n_c0), .wrap(wrap_c0), .match(match_c0)
  );

  ttl_updown_counter_n #(.WIDTH(4), .EDGE_CEN(0)) u_c1 (
    .clk(clk), .Reset(rst), .cen(c_cen), .clr_n(c_clr_n), .load_n(c_load_n),
    .ent_n(rco_n_c0), .enp_n(c_enp_n), .direction(c_dir), .P(c_p[7:4]), .CMP(c_cmp[7:4]),
    .Q(q_c1), .tc(tc_c1), .rco_n(rco_n_c1), .wrap(wrap_c1), .match(match_c1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string       tag;
    logic [31:0] v;
  } exp_t;

  exp_t sb[$];
  int   n_cmp = 0;
  int   n_err = 0;

  task automatic push(input string tag, input logic [31:0] v);
    exp_t e;
    e.tag = tag;
    e.v   = v;
    sb.push_back(e);
  endtask

  task automatic chk(input logic [31:0] obs);
    exp_t e;
    n_cmp++;
    if (sb.size() == 0) begin
      n_err++;
      $error("FAIL scoreboard_empty: observed %0h expected <none>", obs);
    end else begin
      e = sb.pop_front();
      assert (obs === e.v) else begin
        n_err++;
        $error("FAIL %s: observed %0h expected %0h", e.tag, obs, e.v);
      end
    end
  endtask

  // Inputs change and outputs are sampled on the falling edge.
  task automatic cyc();
    @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    rst = 1'b0;
    cen_a = 0; clr_n_a = 1; load_n_a = 1; ent_n_a = 1; enp_n_a = 1; dir_a = 1; p_a = '0; cmp_a = '0;
    cen_b = 0; clr_n_b = 1; load_n_b = 1; ent_n_b = 1; enp_n_b = 1; dir_b = 1; p_b = '0; cmp_b = '0;
    c_cen = 0; c_clr_n = 1; c_load_n = 1; c_ent_n0 = 0; c_enp_n = 0; c_dir = 1; c_p = '0; c_cmp = '0;

    // Reset state
    #1 rst = 1'b1;
    #1;
    push("rst_q_a", 32'h5A);     chk(q_a);
    push("rst_wrap_a", 0);       chk(wrap_a);
    push("rst_match_a", 0);      chk(match_a);
    push("rst_tc_a", 0);         chk(tc_a);
    push("rst_rco_n_a", 1);      chk(rco_n_a);
    push("rst_q_b", 0);          chk(q_b);
    push("rst_tc_b", 0);         chk(tc_b);

    @(negedge clk);
    rst = 1'b0;

    // Count a little, then reset asynchronously mid-count
    ent_n_a = 0; enp_n_a = 0; cen_a = 1;
    push("a_cnt1", 32'h5B); cyc(); chk(q_a);
    cen_a = 0; cyc();
    cen_a = 1;
    push("a_cnt2", 32'h5C); cyc(); chk(q_a);
    cen_a = 0;
    rst = 1'b1; #1;
    push("a_async_rst", 32'h5A); chk(q_a);
    rst = 1'b0;

    // Clear and load together: clear wins, no wrap
    @(negedge clk);
    cen_a = 1; clr_n_a = 0; load_n_a = 0; p_a = 8'h33;
    push("a_clr_over_load", 0); push("a_clr_wrap", 0);
    cyc(); chk(q_a); chk(wrap_a);
    clr_n_a = 1; load_n_a = 1;

    // cen already high at release: first edge ticks
    rst = 1'b1; #1; rst = 1'b0;
    @(negedge clk);
    push("a_release_tick", 32'h5B); chk(q_a);

    // Edge qualification: cen held high 5 clk -> one increment
    cen_a = 0; cyc();
    cen_a = 1;
    repeat (5) cyc();
    push("a_held_cen", 32'h5C); chk(q_a);
    for (int i = 0; i < 10; i++) begin
      cen_a = 0; cyc();
      cen_a = 1; cyc();
    end
    push("a_toggle10", 32'h66); chk(q_a);

    // Compare: match lags Q by one clk
    cen_a = 0; cyc();
    cen_a = 1; load_n_a = 0; p_a = 8'h0E; cmp_a = 8'h10;
    push("a_load_0e", 32'h0E); cyc(); chk(q_a);
    load_n_a = 1; cen_a = 0; cyc();
    cen_a = 1;
    push("a_q_0f", 32'h0F); cyc(); chk(q_a);
    cen_a = 0; cyc();
    cen_a = 1;
    push("a_q_10", 32'h10); push("a_match_early", 0);
    cyc(); chk(q_a); chk(match_a);
    cen_a = 0;
    push("a_match_lag", 1); cyc(); chk(match_a);
    cen_a = 1;
    push("a_q_11", 32'h11); push("a_match_hold", 1);
    cyc(); chk(q_a); chk(match_a);
    cen_a = 0;
    push("a_match_drop", 0); cyc(); chk(match_a);

    // Direction flip at Q=0
    cen_a = 1; clr_n_a = 0;
    push("a_clr", 0); cyc(); chk(q_a);
    clr_n_a = 1; cen_a = 0;
    push("a_tc_up_at0", 0); cyc(); chk(tc_a);
    dir_a = 0; #1;
    push("a_tc_flip", 1); chk(tc_a);
    push("a_rco_flip", 0); chk(rco_n_a);
    push("a_q_flip", 0); chk(q_a);
    @(negedge clk);
    push("a_q_no_tick", 0); cyc(); chk(q_a);
    cen_a = 1;
    push("a_down_wrap_q", 32'hFF); push("a_down_wrap", 1);
    cyc(); chk(q_a); chk(wrap_a);
    cen_a = 0;
    push("a_wrap_clear", 0); push("a_q_hold", 32'hFF);
    cyc(); chk(wrap_a); chk(q_a);

    // Modulus-10 wrap up and down
    cen_b = 1; load_n_b = 0; p_b = 4'd8; dir_b = 1;
    push("b_load8", 8); cyc(); chk(q_b);
    load_n_b = 1; ent_n_b = 0; enp_n_b = 0;
    push("b_q9", 9); push("b_wrap9", 0); push("b_tc9", 1);
    cyc(); chk(q_b); chk(wrap_b); chk(tc_b);
    push("b_q0", 0); push("b_wrap_up", 1); cyc(); chk(q_b); chk(wrap_b);
    push("b_q1", 1); push("b_wrap_off", 0); cyc(); chk(q_b); chk(wrap_b);
    dir_b = 0;
    push("b_dn_q0", 0); push("b_dn_tc0", 1); cyc(); chk(q_b); chk(tc_b);
    push("b_dn_q9", 9); push("b_dn_wrap", 1); push("b_dn_tc9", 0);
    cyc(); chk(q_b); chk(wrap_b); chk(tc_b);

    // Load clamp and enable gating
    load_n_b = 0; p_b = 4'hE;
    push("b_clamp", 9); push("b_clamp_wrap", 0); cyc(); chk(q_b); chk(wrap_b);
    p_b = 4'd3;
    push("b_load3", 3); cyc(); chk(q_b);
    load_n_b = 1; enp_n_b = 1;
    push("b_enp_hold", 3); push("b_rco_tc0", 1); cyc(); chk(q_b); chk(rco_n_b);
    load_n_b = 0; p_b = 4'd0;
    push("b_load0", 0); push("b_load0_wrap", 0); cyc(); chk(q_b); chk(wrap_b);
    load_n_b = 1;
    push("b_enp_hold0", 0); push("b_rco_tc1", 0); cyc(); chk(q_b); chk(rco_n_b);
    ent_n_b = 1; #1;
    push("b_rco_ent_off", 1); chk(rco_n_b);

    // Load MODULUS-1 while counting up -> wraps next tick
    @(negedge clk);
    dir_b = 1; ent_n_b = 0; enp_n_b = 0; load_n_b = 0; p_b = 4'd9;
    push("b_load9", 9); push("b_load9_wrap", 0); cyc(); chk(q_b); chk(wrap_b);
    load_n_b = 1;
    push("b_l9_q0", 0); push("b_l9_wrap", 1); cyc(); chk(q_b); chk(wrap_b);
    cen_b = 0;
    push("b_notick_q", 0); push("b_notick_wrap", 0); cyc(); chk(q_b); chk(wrap_b);

    // Cascade
    c_cen = 1; c_load_n = 0; c_p = 8'h0E;
    push("c_load0e", 32'h0E); cyc(); chk({q_c1, q_c0});
    c_load_n = 1;
    push("c_0f", 32'h0F); cyc(); chk({q_c1, q_c0});
    push("c_10", 32'h10); push("c_w0_10", 1); push("c_w1_10", 0);
    cyc(); chk({q_c1, q_c0}); chk(wrap_c0); chk(wrap_c1);
    push("c_11", 32'h11); cyc(); chk({q_c1, q_c0});
    c_load_n = 0; c_p = 8'hFE;
    push("c_loadfe", 32'hFE); cyc(); chk({q_c1, q_c0});
    c_load_n = 1;
    push("c_ff", 32'hFF); push("c_rco1_ff", 0); cyc(); chk({q_c1, q_c0}); chk(rco_n_c1);
    push("c_00", 32'h00); push("c_w0_00", 1); push("c_w1_00", 1);
    cyc(); chk({q_c1, q_c0}); chk(wrap_c0); chk(wrap_c1);
    c_cen = 0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
